// File: rtl/sample_stream_reader_pkg.sv
// Shared types and constants for the sample stream reader.
package sample_stream_reader_pkg;

  localparam int unsigned SAMPLE_W            = 16;
  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_CAPT  = 3'd3,
    ST_MSB   = 3'd4,
    ST_LSB   = 3'd5
  } state_e;

endpackage

// File: rtl/sample_stream_reader_byte_out_reg.sv
// Output byte holding register: keeps valid/data stable until the
// downstream accepts the byte.
module byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_xfer
);

  logic       valid_d, valid_q;
  logic [7:0] data_d, data_q;

  // A new load wins over a completing transfer so bytes can go back-to-back.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_xfer  = valid_q & i_ready;

endmodule

// File: rtl/sample_stream_reader.sv
// Pops 16-bit samples from the scope sample port and frames them into a
// byte stream: header byte, then MSB/LSB of each sample.
module sample_stream_reader
  import sample_stream_reader_pkg::*;
#(
  parameter int unsigned g_FrameLen   = 64,
  parameter logic [7:0]  g_HeaderByte = HEADER_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_Enable,
  input  logic                userif_SampleEmpty,
  input  logic [SAMPLE_W-1:0] userif_SampleData,
  output logic                userif_SampleRead,
  output logic                o_ByteValid,
  output logic [7:0]          o_ByteData,
  input  logic                i_ByteReady,
  output logic                o_FrameActive,
  output logic [15:0]         o_FrameCount
);

  localparam logic [7:0] FRAME_LAST = 8'(g_FrameLen - 1);

  state_e      state_d, state_q;
  logic [7:0]  cnt_d, cnt_q;
  logic [15:0] fcnt_d, fcnt_q;
  logic        active_d, active_q;
  logic        read_d, read_q;
  logic [7:0]  capt_lsb_d, capt_lsb_q;
  logic        load;
  logic [7:0]  load_data;
  logic        byte_xfer;

  // Next-state, counters and byte loads. The read strobe is registered so it
  // is high during a FETCH cycle: it is requested either on the edge that
  // enters FETCH (source already non-empty) or on the first non-empty cycle
  // while waiting in FETCH. The sample then arrives while in CAPT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    active_d   = active_q;
    read_d     = 1'b0;
    capt_lsb_d = capt_lsb_q;
    load       = 1'b0;
    load_data  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (i_Enable) begin
          state_d   = ST_HDR;
          active_d  = 1'b1;
          load      = 1'b1;
          load_data = g_HeaderByte;
        end
      end
      ST_HDR: begin
        if (byte_xfer) begin
          state_d = ST_FETCH;
          read_d  = ~userif_SampleEmpty;
        end
      end
      ST_FETCH: begin
        if (read_q) begin
          state_d = ST_CAPT;
        end else begin
          read_d = ~userif_SampleEmpty;
        end
      end
      ST_CAPT: begin
        capt_lsb_d = userif_SampleData[7:0];
        load       = 1'b1;
        load_data  = userif_SampleData[15:8];
        state_d    = ST_MSB;
      end
      ST_MSB: begin
        if (byte_xfer) begin
          load      = 1'b1;
          load_data = capt_lsb_q;
          state_d   = ST_LSB;
        end
      end
      ST_LSB: begin
        if (byte_xfer) begin
          if (cnt_q == FRAME_LAST) begin
            cnt_d    = 8'd0;
            fcnt_d   = fcnt_q + 16'd1;
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_FETCH;
            read_d  = ~userif_SampleEmpty;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and capture registers; reset aborts any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      fcnt_q     <= 16'd0;
      active_q   <= 1'b0;
      read_q     <= 1'b0;
      capt_lsb_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      active_q   <= active_d;
      read_q     <= read_d;
      capt_lsb_q <= capt_lsb_d;
    end
  end

  byte_out_reg u_byte_out (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (load),
    .i_data  (load_data),
    .i_ready (i_ByteReady),
    .o_valid (o_ByteValid),
    .o_data  (o_ByteData),
    .o_xfer  (byte_xfer)
  );

  assign userif_SampleRead = read_q;
  assign o_FrameActive     = active_q;
  assign o_FrameCount      = fcnt_q;

endmodule

// File: tb/tb_sample_stream_reader.sv
// Directed/randomized bench for sample_stream_reader with a FIFO source
// model, a byte-stream monitor and a frame-level reference model.
module tb_sample_stream_reader;

  localparam int         FL  = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy;
  logic        empty, rd, vld, active;
  logic [15:0] sdata = 16'd0;
  logic [15:0] fcount;
  logic [7:0]  bdata;

  always #5 clk = ~clk;

  sample_stream_reader #(.g_FrameLen(FL), .g_HeaderByte(HDR)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .i_Enable           (en),
    .userif_SampleEmpty (empty),
    .userif_SampleData  (sdata),
    .userif_SampleRead  (rd),
    .o_ByteValid        (vld),
    .o_ByteData         (bdata),
    .i_ByteReady        (rdy),
    .o_FrameActive      (active),
    .o_FrameCount       (fcount)
  );

  // Source FIFO: pushes by the stimulus, pops on read; data valid next cycle.
  logic [15:0] src_mem [0:255];
  int pushed_n = 0;
  int popped_n = 0;
  assign empty = (pushed_n == popped_n);

  always @(posedge clk) begin
    if (rd) begin
      sdata    <= src_mem[popped_n[7:0]];
      popped_n <= popped_n + 1;
    end
  end

  // Monitor sampled on the falling edge: transfers, reads and hold rule.
  logic [7:0] got [0:1023];
  int   got_n = 0, rd_n = 0, rd_empty_n = 0, hold_err_n = 0, active_cyc = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend && (!vld || bdata != hold_data)) hold_err_n <= hold_err_n + 1;
      hold_pend <= vld && !rdy;
      hold_data <= bdata;
      if (vld && rdy) begin
        got[got_n[9:0]] <= bdata;
        got_n <= got_n + 1;
      end
      if (rd) rd_n <= rd_n + 1;
      if (rd && empty) rd_empty_n <= rd_empty_n + 1;
      if (active) active_cyc <= active_cyc + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] model_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    src_mem[pushed_n[7:0]] = v;
    pushed_n = pushed_n + 1;
    model_q.push_back(v);
  endtask

  // A frame consumes the next FL source samples in order.
  task automatic check_frame(input string tag, input int base);
    logic [7:0]  exp [$];
    logic [15:0] s;
    exp.push_back(HDR);
    for (int k = 0; k < FL; k++) begin
      s = model_q.pop_front();
      exp.push_back(s[15:8]);
      exp.push_back(s[7:0]);
    end
    chk({tag, "_len"}, 32'(got_n - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
  endtask

  task automatic wait_count(input logic [15:0] tgt, input int budget, input string tag);
    int n = 0;
    while (fcount !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(fcount), 32'(tgt));
  endtask

  initial begin
    int base, prev_rd, prev_act, n;
    logic [15:0] a;
    rst_n = 1'b1; en = 1'b0; rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_data", 32'(bdata), 32'd0);
    chk("rst_read", 32'(rd), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_count", 32'(fcount), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Frame 1: preloaded source, ready constantly high.
    push(16'h1234); push(16'hABCD);
    push(16'($urandom)); push(16'($urandom));
    base = got_n; prev_rd = rd_n; prev_act = active_cyc;
    rdy = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    wait_count(16'd1, 100, "f1");
    chk("f1_active_fall", 32'(active), 32'd0);
    check_frame("f1", base);
    chk("f1_reads", 32'(rd_n - prev_rd), 32'(FL));
    chk("f1_active_cycles", 32'(active_cyc - prev_act), 32'(1 + 4 * FL));

    // Frame 2: ready toggling, enable dropped after the header transfer.
    for (int k = 0; k < FL; k++) push(16'($urandom));
    base = got_n; en = 1'b1; n = 0;
    while (fcount !== 16'd2 && n < 300) begin
      rdy = ~rdy;
      if (got_n > base) en = 1'b0;
      tick();
      n++;
    end
    chk("f2_done", 32'(fcount), 32'd2);
    check_frame("f2", base);
    chk("f2_hold", 32'(hold_err_n), 32'd0);
    base = got_n; rdy = 1'b1;
    repeat (6) tick();
    chk("f2_no_new_hdr", 32'(got_n), 32'(base));
    chk("f2_idle_valid", 32'(vld), 32'd0);
    chk("f2_idle_active", 32'(active), 32'd0);

    // Frame 3: source runs dry after one sample, random ready.
    push(16'($urandom));
    base = got_n; prev_rd = rd_n;
    en = 1'b1; tick(); en = 1'b0;
    n = 0;
    while (got_n < base + 3 && n < 50) begin tick(); n++; end
    chk("f3_first_sample", 32'(got_n - base), 32'd3);
    for (int k = 0; k < 20; k++) begin
      rdy = 1'($urandom_range(0, 1));
      tick();
    end
    chk("f3_stall_reads", 32'(rd_n - prev_rd), 32'd1);
    chk("f3_stall_valid", 32'(vld), 32'd0);
    chk("f3_stall_active", 32'(active), 32'd1);
    push(16'h00FF); push(16'($urandom)); push(16'($urandom));
    n = 0;
    while (fcount !== 16'd3 && n < 300) begin
      rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("f3_done", 32'(fcount), 32'd3);
    check_frame("f3", base);
    chk("hold_total", 32'(hold_err_n), 32'd0);
    chk("read_while_empty", 32'(rd_empty_n), 32'd0);

    // Reset while the MSB byte is stalled by ready low.
    for (int k = 0; k < FL; k++) push(16'($urandom));
    a = model_q[0];
    base = got_n; rdy = 1'b1; en = 1'b1; n = 0;
    while (got_n == base && n < 20) begin tick(); n++; end
    rdy = 1'b0; en = 1'b0; n = 0;
    while (!vld && n < 10) begin tick(); n++; end
    chk("r_msb_valid", 32'(vld), 32'd1);
    chk("r_msb_data", 32'(bdata), 32'(a[15:8]));
    #1 rst_n = 1'b0;
    #1;
    chk("r_valid", 32'(vld), 32'd0);
    chk("r_data", 32'(bdata), 32'd0);
    chk("r_read", 32'(rd), 32'd0);
    chk("r_active", 32'(active), 32'd0);
    chk("r_count", 32'(fcount), 32'd0);
    void'(model_q.pop_front());
    push(16'($urandom));
    tick();
    rst_n = 1'b1; rdy = 1'b1;
    base = got_n; en = 1'b1;
    tick();
    en = 1'b0;
    wait_count(16'd1, 100, "r_frame");
    check_frame("r_frame", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_stream_reader.md
Name: sample_stream_reader

Overview:
- Host-side consumer of the oscilloscope user-interface sample port (userif_SampleRead / userif_SampleEmpty / userif_SampleData).
- Pops 16-bit samples whenever the port reports non-empty.
- Frames the samples into a byte stream: one header byte, then the MSB and LSB of each sample.
- Drives a valid/ready byte interface feeding a UART transmitter or a host link.

Parameters:
- g_FrameLen, 64, samples per frame (2..255).
- g_HeaderByte, 8'hA5, byte emitted at the start of every frame.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- i_Enable  input  1  streaming enable; sampled only at frame boundaries
- userif_SampleEmpty  input  1  source sample FIFO empty
- userif_SampleData  input  16  sample word; valid the cycle after userif_SampleRead
- userif_SampleRead  output  1  one-cycle pop strobe to the source
- o_ByteValid  output  1  byte available
- o_ByteData  output  8  byte value
- i_ByteReady  input  1  downstream accepts the byte this cycle
- o_FrameActive  output  1  a frame is in progress
- o_FrameCount  output  16  completed frames, wraps 16'hFFFF->0

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to 0.
- After reset the FSM is in IDLE with sample counter 0 and capture register 0.
- Byte handshake: a transfer occurs on a clock edge with o_ByteValid=1 and i_ByteReady=1.
  - Once asserted, o_ByteValid and o_ByteData hold stable until the transfer.
  - i_ByteReady may be constant 1.
- FSM states:
  - IDLE: if i_Enable=1, go to HDR and set o_FrameActive=1; otherwise stay.
  - HDR: o_ByteValid=1, o_ByteData=g_HeaderByte. On transfer go to FETCH.
  - FETCH: if userif_SampleEmpty=0, assert userif_SampleRead for exactly one cycle and go to CAPT. Otherwise wait in FETCH indefinitely; there is no timeout.
  - CAPT: register userif_SampleData, go to MSB.
  - MSB: present data[15:8]. On transfer go to LSB.
  - LSB: present data[7:0]. On transfer, increment the sample counter.
    - If the counter reaches g_FrameLen: clear the counter, increment o_FrameCount, clear o_FrameActive, return to IDLE.
    - Otherwise go to FETCH.
- userif_SampleRead:
  - Registered output.
  - Never asserted while userif_SampleEmpty=1.
  - Never asserted outside FETCH.
  - At most one outstanding read.
- Latency: with Empty=0 and Ready=1 throughout, the first sample takes FETCH→CAPT→MSB→LSB = 4 cycles. Steady-state throughput is one sample per 4 cycles; the header adds 1 cycle per frame.
- i_Enable deasserted mid-frame has no effect until the frame completes: the full g_FrameLen samples are always emitted. A back-to-back frame starts only if i_Enable=1 in IDLE.
- Empty toggling mid-frame: the FSM stalls in FETCH with o_ByteValid=0 and resumes on the next non-empty cycle.
- Ready low: the FSM stalls in HDR/MSB/LSB and no new read is issued.
- Reset asserted mid-frame:
  - Aborts immediately; a partial frame is discarded.
  - o_FrameCount clears.
  - A pending read's data is dropped.
- o_FrameCount increments on the same edge as the final LSB transfer.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, HDR, FETCH, CAPT, MSB, LSB, 3-bit.
  - Default header constant 8'hA5.
  - Sample width 16.
- One natural sub-module, byte_out_reg: the valid/data holding register with the ready handshake.
- The FSM and counters stay in the top.

Test Plan:
- g_FrameLen=2, Enable=1, source preloaded with 16'h1234 and 16'hABCD, Ready=1 → bytes A5,12,34,AB,CD; exactly 2 read strobes; o_FrameCount=1; o_FrameActive falls with the CD transfer.
- Ready toggled 1/0 every cycle during the same frame → identical byte sequence; o_ByteData never changes while Valid=1 and Ready=0.
- Source empty after the first sample for 20 cycles, then 16'h00FF pushed → FSM waits in FETCH with no Read while Empty=1; then emits 00,FF.
- Enable dropped after the header of a 4-sample frame → all 4 samples still emitted; FSM then returns to IDLE with no further header.
- Async reset asserted while in MSB → all outputs 0 within the same cycle; after release with Enable=1 the next byte is A5.
- o_FrameCount forced near wrap (run 65536 frames of g_FrameLen=2 in a fast sim) → counter wraps 16'hFFFF→16'h0000.
